// File: rtl/press_decoder.sv
// press_decoder: turns the debounced button level into single-cycle events.
// The events are a short press, a long press and auto-repeat while the button
// stays down, plus a held level.
// After reset the block waits for the button to be seen released, so a button
// that is already down when reset ends produces no events.
module press_decoder #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inButton,
    output logic shortPress,
    output logic longPress,
    output logic repeatPulse,
    output logic held
);

    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ARMWAIT = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        LONG    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          held_q, held_d;

    logic [HW-1:0] hold_inc;
    logic [RW-1:0] rep_inc;
    logic          hold_done;
    logic          rep_done;

    // Incremented counters and their terminal-count tests, shared by both comb blocks.
    always_comb begin
        hold_inc  = hold_q + HW'(1);
        rep_inc   = rep_q + RW'(1);
        hold_done = (hold_inc == HOLD_LAST);
        rep_done  = (rep_inc == REP_LAST);
    end

    // State, hold counter and repeat counter registers.
    // All of them clear asynchronously when reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARMWAIT;
            hold_q  <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
        end
    end

    // Next-state logic.
    // The hold counter freezes once LONG is entered, so an endless hold cannot wrap.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        unique case (state_q)
            ARMWAIT: begin
                if (!inButton) state_d = IDLE;
            end
            IDLE: begin
                if (inButton) begin
                    state_d = PRESSED;
                    hold_d  = HW'(1);
                end
            end
            PRESSED: begin
                if (!inButton) begin
                    state_d = IDLE;
                end else if (hold_done) begin
                    state_d = LONG;
                    hold_d  = hold_inc;
                    rep_d   = '0;
                end else begin
                    hold_d  = hold_inc;
                end
            end
            LONG: begin
                if (!inButton) begin
                    state_d = IDLE;
                end else if (rep_done) begin
                    rep_d = '0;
                end else begin
                    rep_d = rep_inc;
                end
            end
            default: state_d = ARMWAIT;
        endcase
    end

    // Output decode.
    // Each pulse is raised on the edge that takes the qualifying sample.
    // held simply mirrors "next state is LONG".
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        held_d   = (state_d == LONG);
        unique case (state_q)
            PRESSED: begin
                short_d = !inButton;
                long_d  = inButton && hold_done;
            end
            LONG: begin
                repeat_d = inButton && rep_done;
            end
            default: ;
        endcase
    end

    // Registered outputs. They drop to 0 immediately when reset goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign shortPress  = short_q;
    assign longPress   = long_q;
    assign repeatPulse = repeat_q;
    assign held        = held_q;

endmodule
